// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - stream bundle shared between requesters, the arbiter and the sink
//
// Purpose: carries the N request streams (s_*) and the single output stream (m_*)
// of axis_rr_arbiter.
//
// Modports:
//   master - environment view: drives s_valid/s_data/s_last and m_ready,
//            observes s_ready and the m_* beat.
//   slave  - arbiter view: the mirror image of master.
//
// Signals:
//   s_valid [N]        per-channel valid
//   s_ready [N]        per-channel ready, at most one bit set
//   s_data  [N*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   s_last  [N]        per-channel packet end
//   m_valid, m_ready   output handshake
//   m_data  [WIDTH]    output beat
//   m_last             registered packet end of the output beat
//   m_id    [ID_BITS]  source channel of the output beat

interface axis_rr_arbiter_if #(
   parameter int N       = 4,
   parameter int WIDTH   = 8,
   parameter int ID_BITS = 2
);
   logic [N-1:0]       s_valid;
   logic [N-1:0]       s_ready;
   logic [N*WIDTH-1:0] s_data;
   logic [N-1:0]       s_last;
   logic               m_valid;
   logic               m_ready;
   logic [WIDTH-1:0]   m_data;
   logic               m_last;
   logic [ID_BITS-1:0] m_id;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last, m_id
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last, m_id
   );
endinterface

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - N-to-1 round-robin stream arbiter with burst limit and registered output
//
// Purpose: shares one stream sink between N requesters. Grants rotate round-robin
// starting after the previous winner; a grant ends after MAX_BURST beats or when
// the granted source drops valid. One idle arbitration cycle separates grants.
//
// Optional feature macro: ARB_LAST_LOCK_EN
//   defined   - a grant is held until a beat with s_last=1 is accepted (packet-atomic),
//               ignoring the burst limit and valid gaps; m_last mirrors s_last.
//   undefined - s_last is ignored and m_last is 0.
//
// Ports:
//   clk      clock
//   rst      synchronous reset, active-high
//   bus      axis_rr_arbiter_if.slave (s_* requests in, m_* beat out)
//   grant_oh one-hot current grant, 0 while idle
//   busy     1 while a grant is held or an output beat is pending

module axis_rr_arbiter #(
   parameter int N         = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 16,
   parameter int ID_BITS   = 2
) (
   input  logic            clk,
   input  logic            rst,
   axis_rr_arbiter_if.slave bus,
   output logic [N-1:0]    grant_oh,
   output logic            busy
);
   localparam int CNT_BITS = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state, state_next;
   logic [ID_BITS-1:0]  g, g_next;
   logic [ID_BITS-1:0]  last_grant, last_next;
   logic [CNT_BITS-1:0] burst_cnt, cnt_next;

   logic                any_valid;
   logic [ID_BITS-1:0]  pick;
   logic                g_valid;
   logic                g_last;
   logic [WIDTH-1:0]    g_data;
   logic                out_ready;
   logic                take;
   logic                release_grant;

   logic                m_valid_q;
   logic [WIDTH-1:0]    m_data_q;
   logic [ID_BITS-1:0]  m_id_q;
   logic                m_last_q;

   // Round-robin scan from last_grant+1 with explicit wrap, so non-power-of-2 N
   // never produces an index >= N.
   always_comb begin
      any_valid = 1'b0;
      pick      = '0;
      for (int k = 1; k <= N; k++) begin
         int                 idx;
         logic [ID_BITS-1:0] cand;
         idx = int'(last_grant) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         cand = ID_BITS'(idx);
         if (!any_valid && bus.s_valid[cand]) begin
            any_valid = 1'b1;
            pick      = cand;
         end
      end
   end

   // Granted channel's request fields, selected with constant indices.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (g == ID_BITS'(i)) begin
            g_valid = bus.s_valid[i];
            g_last  = bus.s_last[i];
            g_data  = bus.s_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // The output register can take a beat when empty or draining this cycle.
   assign out_ready = ~m_valid_q | bus.m_ready;
   assign take      = (state == GRANT) && g_valid && out_ready && !rst;

`ifdef ARB_LAST_LOCK_EN
   assign release_grant = take && g_last;
`else
   assign release_grant = (take && (burst_cnt == CNT_BITS'(MAX_BURST - 1))) || !g_valid;
`endif

   // Ready is gated by rst so no beat is accepted in the reset cycle.
   always_comb begin
      bus.s_ready = '0;
      grant_oh    = '0;
      for (int i = 0; i < N; i++) begin
         if ((state == GRANT) && (g == ID_BITS'(i))) begin
            grant_oh[i]    = 1'b1;
            bus.s_ready[i] = out_ready && !rst;
         end
      end
   end

   always_comb begin
      state_next = state;
      g_next     = g;
      last_next  = last_grant;
      cnt_next   = burst_cnt;
      case (state)
         IDLE: begin
            if (any_valid) begin
               state_next = GRANT;
               g_next     = pick;
               cnt_next   = '0;
            end
         end
         GRANT: begin
            if (take) begin
               cnt_next = burst_cnt + 1'b1;
            end
            if (release_grant) begin
               state_next = IDLE;
               last_next  = g;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         g          <= '0;
         last_grant <= ID_BITS'(N - 1);
         burst_cnt  <= '0;
      end else begin
         state      <= state_next;
         g          <= g_next;
         last_grant <= last_next;
         burst_cnt  <= cnt_next;
      end
   end

   // Output stage: load on transfer, clear when drained, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_id_q    <= '0;
         m_last_q  <= 1'b0;
      end else if (take) begin
         m_valid_q <= 1'b1;
         m_data_q  <= g_data;
         m_id_q    <= g;
`ifdef ARB_LAST_LOCK_EN
         m_last_q  <= g_last;
`else
         m_last_q  <= 1'b0;
`endif
      end else if (bus.m_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_id    = m_id_q;
   assign bus.m_last  = m_last_q;
   assign busy        = (state == GRANT) || m_valid_q;

endmodule
